// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the register-file write port between the CPU
// writeback path and a four-phase debug request channel. The CPU path has
// priority; a debug access takes the port only in a cycle where the CPU is
// not writing (or is being held off by cpu_stall).
//
// Build option: define RF_ARB_STALL_EN to enable the starvation guard. With
// it, a debug request denied STARVE_LIMIT times in a row raises cpu_stall so
// the debug access is guaranteed to complete. Without it, cpu_stall is tied
// low and a debug request waits for a cycle with cpu_we=0.
//
// Timing, with the request first seen in IDLE at rising edge N:
//   cycle after N   : WAIT, debug owns the write port if granted
//   cycle after N+1 : ACK, dbg_ack high, dbg_rdata valid
// i.e. the register-file write appears one cycle after dbg_req is raised
// and dbg_ack two cycles after it is raised.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no debug access pending; port follows the CPU
// WAIT   | request latched; waiting for a cycle in which the CPU yields
// ACK    | access done; dbg_ack held until dbg_req falls

module regfile_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        cpu_we,
    input  logic [4:0]  cpu_waddr,
    input  logic [31:0] cpu_wdata,

    input  logic        dbg_req,
    input  logic        dbg_wr,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    output logic [4:0]  rf_dbg_raddr,
    input  logic [31:0] rf_dbg_rdata,

    output logic        cpu_stall
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]  state;
    logic        req_wr;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        in_wait;
    logic        grant;

    assign in_wait = (state == S_WAIT);

    // Debug owns the port when waiting and the CPU is either idle or held off.
    assign grant = in_wait && (!cpu_we || cpu_stall);

    // Request sequencing, request-field capture and debug read-data capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            req_wr    <= 1'b0;
            req_addr  <= 5'd0;
            req_wdata <= 32'd0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dbg_req) begin
                        req_wr    <= dbg_wr;
                        req_addr  <= dbg_addr;
                        req_wdata <= dbg_wdata;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A dropped dbg_req is ignored here: the access still
                    // completes and ACK then exits after a single cycle.
                    if (grant) begin
                        dbg_rdata <= rf_dbg_rdata;
                        dbg_ack   <= 1'b1;
                        state     <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!dbg_req) begin
                        dbg_ack <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    dbg_ack <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RF_ARB_STALL_EN
    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    logic [3:0] starve_cnt;
    logic       denied;

    assign denied = in_wait && cpu_we && !cpu_stall;

    // Count consecutive denied cycles and hold the CPU off once the limit is hit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
            cpu_stall  <= 1'b0;
        end else begin
            if ((state == S_IDLE) && dbg_req) begin
                starve_cnt <= 4'd0;
            end else if (denied && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            // WAIT is left only through a grant, so that clears the stall.
            if (denied && (starve_cnt == LIMIT_M1)) begin
                cpu_stall <= 1'b1;
            end else if (grant) begin
                cpu_stall <= 1'b0;
            end
        end
    end
`else
    assign cpu_stall = 1'b0;
`endif

    // Debug read port looks at the live address until the request is latched.
    always_comb begin
        rf_dbg_raddr = req_addr;
        if (state == S_IDLE) begin
            rf_dbg_raddr = dbg_addr;
        end
    end

    // Write-port mux; register 0 is filtered on both paths.
    always_comb begin
        rf_we    = cpu_we && (cpu_waddr != 5'd0);
        rf_waddr = cpu_waddr;
        rf_wdata = cpu_wdata;
        if (grant) begin
            rf_we    = req_wr && (req_addr != 5'd0);
            rf_waddr = req_addr;
            rf_wdata = req_wdata;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file behind
// the write port and the debug read port. Build with RF_ARB_STALL_EN defined
// to exercise the starvation guard instead of the indefinite-wait case.

module tb_regfile_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_we;
    logic [4:0]  cpu_waddr;
    logic [31:0] cpu_wdata;
    logic        dbg_req;
    logic        dbg_wr;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_dbg_raddr;
    logic [31:0] rf_dbg_rdata;
    logic        cpu_stall;

    logic [31:0] regs [32] = '{default: 32'd0};
    int          r0_hits = 0;
    int          r9_hits = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          stall_seen = 0;

    regfile_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_we       (cpu_we),
        .cpu_waddr    (cpu_waddr),
        .cpu_wdata    (cpu_wdata),
        .dbg_req      (dbg_req),
        .dbg_wr       (dbg_wr),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_ack      (dbg_ack),
        .dbg_rdata    (dbg_rdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_dbg_raddr (rf_dbg_raddr),
        .rf_dbg_rdata (rf_dbg_rdata),
        .cpu_stall    (cpu_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register-file model plus watchers for writes that must never happen.
    always @(posedge clock) begin
        if (rf_we) begin
            regs[rf_waddr] <= rf_wdata;
            if (rf_waddr == 5'd0) r0_hits <= r0_hits + 1;
            if (rf_waddr == 5'd9) r9_hits <= r9_hits + 1;
        end
    end

    assign rf_dbg_rdata = regs[rf_dbg_raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    initial begin
        reset     = 1'b1;
        cpu_we    = 1'b1;
        cpu_waddr = 5'd3;
        cpu_wdata = 32'h11;
        dbg_req   = 1'b0;
        dbg_wr    = 1'b0;
        dbg_addr  = 5'd0;
        dbg_wdata = 32'd0;

        // Reset state; write port follows the CPU.
        at_neg();
        check("rst_ack", 32'(dbg_ack), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_rdata", dbg_rdata, 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd1);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd3);
        cpu_we = 1'b0;
        step();
        reset = 1'b0;

        // Debug write r5 with an idle CPU; live inputs change after latching.
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEADBEEF;
        at_neg();
        check("t1_idle_we", 32'(rf_we), 32'd0);
        step();
        dbg_addr = 5'd9; dbg_wdata = 32'h0; dbg_wr = 1'b0;
        at_neg();
        check("t1_we", 32'(rf_we), 32'd1);
        check("t1_waddr", 32'(rf_waddr), 32'd5);
        check("t1_wdata", rf_wdata, 32'hDEADBEEF);
        check("t1_ack_early", 32'(dbg_ack), 32'd0);
        step();
        at_neg();
        check("t1_ack", 32'(dbg_ack), 32'd1);
        check("t1_rdata_prewrite", dbg_rdata, 32'd0);
        check("t1_ack_rf_we", 32'(rf_we), 32'd0);
        check("t1_r5", regs[5], 32'hDEADBEEF);
        dbg_req = 1'b0;
        step();
        at_neg();
        check("t1_ack_low", 32'(dbg_ack), 32'd0);

        // Debug read r5.
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd5;
        step();
        at_neg();
        check("t2_we", 32'(rf_we), 32'd0);
        check("t2_raddr", 32'(rf_dbg_raddr), 32'd5);
        step();
        at_neg();
        check("t2_ack", 32'(dbg_ack), 32'd1);
        check("t2_rdata", dbg_rdata, 32'hDEADBEEF);
        dbg_req = 1'b0;
        step();
        at_neg();

        // CPU writes r3 while debug targets r0.
        cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'h55;
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFF;
        #1;
        check("t3_cpu_we", 32'(rf_we), 32'd1);
        check("t3_cpu_waddr", 32'(rf_waddr), 32'd3);
        check("t3_cpu_wdata", rf_wdata, 32'h55);
        step();
        cpu_we = 1'b0;
        at_neg();
        check("t3_r0_we", 32'(rf_we), 32'd0);
        step();
        at_neg();
        check("t3_ack", 32'(dbg_ack), 32'd1);
        check("t3_r3", regs[3], 32'h55);
        dbg_req = 1'b0;
        cpu_we = 1'b1; cpu_waddr = 5'd0;
        #1;
        check("t3_cpu_r0_we", 32'(rf_we), 32'd0);
        cpu_we = 1'b0;
        step();
        at_neg();
        check("t3_r0_hits", 32'(r0_hits), 32'd0);

        // Request dropped while waiting behind CPU writes still completes.
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd3;
        cpu_we = 1'b1; cpu_waddr = 5'd4; cpu_wdata = 32'h44;
        step();
        dbg_req = 1'b0;
        at_neg();
        check("t4_cpu_pass_we", 32'(rf_we), 32'd1);
        check("t4_cpu_pass_waddr", 32'(rf_waddr), 32'd4);
        check("t4_ack_wait", 32'(dbg_ack), 32'd0);
        step();
        at_neg();
        cpu_we = 1'b0;
        #1;
        check("t4_grant_we", 32'(rf_we), 32'd0);
        check("t4_raddr", 32'(rf_dbg_raddr), 32'd3);
        step();
        at_neg();
        check("t4_ack", 32'(dbg_ack), 32'd1);
        check("t4_rdata", dbg_rdata, 32'h55);
        step();
        at_neg();
        check("t4_ack_low", 32'(dbg_ack), 32'd0);

        // Reset while waiting aborts the request.
        cpu_we = 1'b1; cpu_waddr = 5'd6; cpu_wdata = 32'h66;
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hAA;
        step();
        reset = 1'b1;
        at_neg();
        check("t5_ack", 32'(dbg_ack), 32'd0);
        check("t5_stall", 32'(cpu_stall), 32'd0);
        check("t5_cpu_we", 32'(rf_we), 32'd1);
        check("t5_cpu_waddr", 32'(rf_waddr), 32'd6);
        cpu_we = 1'b0;
        #1;
        check("t5_we_off", 32'(rf_we), 32'd0);
        step();
        dbg_req = 1'b0;
        step();
        reset = 1'b0;
        step();
        at_neg();
        check("t5_r9_hits", 32'(r9_hits), 32'd0);
        check("t5_ack_idle", 32'(dbg_ack), 32'd0);
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd6;
        step();
        step();
        at_neg();
        check("t5_post_ack", 32'(dbg_ack), 32'd1);
        check("t5_post_rdata", dbg_rdata, 32'h66);
        dbg_req = 1'b0;
        step();
        at_neg();

`ifdef RF_ARB_STALL_EN
        // Continuous CPU writes: four denials, then a forced stall.
        cpu_we = 1'b1; cpu_waddr = 5'd1; cpu_wdata = 32'h100;
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h1234;
        step();
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check($sformatf("t6_deny%0d_stall", i), 32'(cpu_stall), 32'd0);
            check($sformatf("t6_deny%0d_waddr", i), 32'(rf_waddr), 32'd1);
            step();
        end
        at_neg();
        check("t6_stall", 32'(cpu_stall), 32'd1);
        check("t6_we", 32'(rf_we), 32'd1);
        check("t6_waddr", 32'(rf_waddr), 32'd7);
        check("t6_wdata", rf_wdata, 32'h1234);
        step();
        at_neg();
        check("t6_ack", 32'(dbg_ack), 32'd1);
        check("t6_stall_low", 32'(cpu_stall), 32'd0);
        check("t6_r7", regs[7], 32'h1234);
        dbg_req = 1'b0; cpu_we = 1'b0;
        step();
`else
        // Without the guard the debug access waits out 20 CPU write cycles.
        cpu_we = 1'b1; cpu_waddr = 5'd1; cpu_wdata = 32'h100;
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h1234;
        step();
        for (int i = 0; i < 20; i++) begin
            at_neg();
            if (cpu_stall !== 1'b0 || dbg_ack !== 1'b0 || rf_waddr !== 5'd1) stall_seen++;
            if (i < 19) step();
        end
        check("t6_wait_clean", 32'(stall_seen), 32'd0);
        cpu_we = 1'b0;
        #1;
        check("t6_we", 32'(rf_we), 32'd1);
        check("t6_waddr", 32'(rf_waddr), 32'd7);
        check("t6_wdata", rf_wdata, 32'h1234);
        step();
        at_neg();
        check("t6_ack", 32'(dbg_ack), 32'd1);
        check("t6_stall", 32'(cpu_stall), 32'd0);
        check("t6_r7", regs[7], 32'h1234);
        dbg_req = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
